// File: rtl/inst_rom_loader.sv
// Instruction memory for the openmips fetch port, reloadable at run time from a
// byte-serial, big-endian program image while the core is held in reset.
module inst_rom_loader #(
   parameter int DEPTH_LOG2 = 10
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  rom_ce_i,
   input  logic [31:0]           rom_addr_i,
   output logic [31:0]           rom_data_o,
   input  logic                  ld_start_i,
   input  logic [DEPTH_LOG2:0]   ld_len_i,
   input  logic                  ld_valid_i,
   input  logic [7:0]            ld_byte_i,
   output logic                  ld_ready_o,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  cpu_rst_o
);

   localparam int                DEPTH     = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] DEPTH_LEN = (DEPTH_LOG2 + 1)'(DEPTH);

   // Handshake: a loader byte transfers on a rising edge where ld_valid_i and
   // ld_ready_o are both high; ld_valid_i may drop between bytes without loss.

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t                  state;
   state_t                  state_nxt;

   logic [31:0]             mem [DEPTH];
   logic [DEPTH_LOG2-1:0]   wptr;
   logic [1:0]              bcnt;
   logic [23:0]             shreg;
   logic [DEPTH_LOG2:0]     len_q;
   logic [DEPTH_LOG2:0]     len_clamped;

   logic                    start_ok;
   logic                    accept;
   logic                    word_done;
   logic                    last_word;

   logic [DEPTH_LOG2-1:0]   fetch_idx;
   logic                    fetch_in_range;
   logic                    unused_addr_bits;

   assign start_ok    = (state == IDLE) && ld_start_i && (ld_len_i != '0);
   assign len_clamped = (ld_len_i > DEPTH_LEN) ? DEPTH_LEN : ld_len_i;
   assign accept      = (state == LOAD) && ld_valid_i;
   assign word_done   = accept && (bcnt == 2'd3);
   assign last_word   = ({1'b0, wptr} == (len_q - 1'b1));

   // State register
   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (start_ok) begin
               state_nxt = LOAD;
            end
         end
         LOAD: begin
            if (word_done && last_word) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Output decode; the core stays in reset whenever the memory is not stable
   always_comb begin
      ld_ready_o = 1'b0;
      busy_o     = 1'b0;
      done_o     = 1'b0;
      cpu_rst_o  = ~rst;
      case (state)
         LOAD: begin
            ld_ready_o = 1'b1;
            busy_o     = 1'b1;
            cpu_rst_o  = 1'b1;
         end
         DONE: begin
            done_o    = 1'b1;
            cpu_rst_o = 1'b1;
         end
         default: begin
         end
      endcase
   end

   // Loader datapath: byte assembly and word pointer
   always_ff @(posedge clk) begin
      if (!rst) begin
         wptr  <= '0;
         bcnt  <= '0;
         shreg <= '0;
         len_q <= '0;
      end else if (start_ok) begin
         wptr  <= '0;
         bcnt  <= '0;
         len_q <= len_clamped;
      end else if (accept) begin
         shreg <= {shreg[15:0], ld_byte_i};
         bcnt  <= bcnt + 2'd1;
         if (bcnt == 2'd3) begin
            wptr <= wptr + 1'b1;
         end
      end
   end

   // The array is deliberately left out of reset so a program survives rst.
   always_ff @(posedge clk) begin
      if (rst && word_done) begin
         mem[wptr] <= {shreg, ld_byte_i};
      end
   end

   assign fetch_idx        = rom_addr_i[DEPTH_LOG2+1:2];
   assign fetch_in_range   = (rom_addr_i[31:DEPTH_LOG2+2] == '0);
   assign unused_addr_bits = ^rom_addr_i[1:0];

   always_comb begin
      rom_data_o = '0;
      if (rst && rom_ce_i && fetch_in_range && (state == IDLE)) begin
         rom_data_o = mem[fetch_idx];
      end
   end

endmodule

// File: tb/tb_inst_rom_loader.sv
// Directed-plus-random bench for inst_rom_loader; a word-level memory model
// predicts fetch results after each load.
module tb_inst_rom_loader;

  localparam int DL    = 10;
  localparam int DEPTH = 1 << DL;

  logic          clk = 1'b0;
  logic          rst;
  logic          rom_ce;
  logic [31:0]   rom_addr;
  logic [31:0]   rom_data;
  logic          ld_start;
  logic [DL:0]   ld_len;
  logic          ld_valid;
  logic [7:0]    ld_byte;
  logic          ld_ready;
  logic          busy;
  logic          done;
  logic          cpu_rst;

  int tests = 0;
  int fails = 0;

  logic [31:0] model_mem [DEPTH];
  bit          known     [DEPTH];
  logic [7:0]  pre_q [$];
  logic [31:0] old1;

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  inst_rom_loader #(.DEPTH_LOG2(DL)) dut (
    .clk        (clk),
    .rst        (rst),
    .rom_ce_i   (rom_ce),
    .rom_addr_i (rom_addr),
    .rom_data_o (rom_data),
    .ld_start_i (ld_start),
    .ld_len_i   (ld_len),
    .ld_valid_i (ld_valid),
    .ld_byte_i  (ld_byte),
    .ld_ready_o (ld_ready),
    .busy_o     (busy),
    .done_o     (done),
    .cpu_rst_o  (cpu_rst)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_b(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_w(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Fetch check against the model; words never loaded are skipped.
  task automatic fetch_chk(input string tag, input logic [31:0] addr);
    logic [31:0] exp;
    int          idx;
    rom_ce   = 1'b1;
    rom_addr = addr;
    #1;
    if (addr[31:DL+2] != '0) begin
      exp = 32'h0;
    end else begin
      idx = int'(addr[DL+1:2]);
      if (!known[idx]) return;
      exp = model_mem[idx];
    end
    check_w(tag, rom_data, exp);
  endtask

  task automatic fetch_const(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    rom_ce   = 1'b1;
    rom_addr = addr;
    #1;
    check_w(tag, rom_data, exp);
  endtask

  function automatic logic [31:0] rand_addr();
    return {20'h0, 10'($urandom_range(0, DEPTH - 1)), 2'($urandom_range(0, 3))};
  endfunction

  // Driver: one complete load. gap_mode 0 = back-to-back, 1 = toggling valid,
  // 2 = random gaps. abort_after >= 0 pulls rst after that many bytes.
  task automatic run_load(input int len_req, input int gap_mode, input int abort_after);
    int          eff;
    int          total;
    int          sent;
    int          iter;
    bit          v;
    logic [31:0] acc;
    eff   = (len_req > DEPTH) ? DEPTH : len_req;
    total = eff * 4;
    sent  = 0;
    iter  = 0;
    acc   = 32'h0;
    ld_start = 1'b1;
    ld_len   = len_req[DL:0];
    tick();
    ld_start = 1'b0;
    check_b("busy_after_start", busy, 1'b1);
    check_b("ready_after_start", ld_ready, 1'b1);
    check_b("cpu_rst_in_load", cpu_rst, 1'b1);
    while (sent < total) begin
      if (iter > total * 8 + 16) begin
        check_w("load_cycle_budget", 32'(sent), 32'(total));
        return;
      end
      if (abort_after >= 0 && sent == abort_after) begin
        rst      = 1'b0;
        ld_valid = 1'b0;
        ld_start = 1'b0;
        tick();
        check_b("abort_busy", busy, 1'b0);
        check_b("abort_ready", ld_ready, 1'b0);
        check_b("abort_done", done, 1'b0);
        check_b("abort_cpu_rst", cpu_rst, 1'b1);
        fetch_const("abort_fetch_in_rst", 32'h0, 32'h0);
        rst = 1'b1;
        #1;
        check_b("abort_cpu_rst_release", cpu_rst, 1'b0);
        tick();
        check_b("abort_no_done", done, 1'b0);
        check_b("abort_idle", busy, 1'b0);
        return;
      end
      case (gap_mode)
        0:       v = 1'b1;
        1:       v = (iter % 2 == 0);
        default: v = ($urandom_range(0, 3) != 0);
      endcase
      ld_valid = v;
      if (v) ld_byte = (pre_q.size() > 0) ? pre_q.pop_front() : 8'($urandom_range(0, 255));
      ld_start = ($urandom_range(0, 7) == 0);
      ld_len   = 11'($urandom_range(1, 2047));
      rom_ce   = 1'b1;
      rom_addr = rand_addr();
      #1;
      check_b("busy_in_load", busy, 1'b1);
      check_w("fetch_zero_in_load", rom_data, 32'h0);
      tick();
      iter++;
      if (v) begin
        acc = (acc << 8) | {24'h0, ld_byte};
        sent++;
        if (sent % 4 == 0) begin
          model_mem[sent / 4 - 1] = acc;
          known[sent / 4 - 1]     = 1'b1;
        end
      end
    end
    ld_valid = 1'b0;
    ld_start = 1'b1;
    ld_len   = 11'd5;
    check_b("done_pulse", done, 1'b1);
    check_b("ready_in_done", ld_ready, 1'b0);
    check_b("busy_in_done", busy, 1'b0);
    check_b("cpu_rst_in_done", cpu_rst, 1'b1);
    fetch_const("fetch_zero_in_done", 32'h0, 32'h0);
    tick();
    ld_start = 1'b0;
    check_b("done_one_cycle", done, 1'b0);
    check_b("idle_after_done", busy, 1'b0);
    check_b("cpu_rst_released", cpu_rst, 1'b0);
  endtask

  initial begin
    rst      = 1'b0;
    rom_ce   = 1'b1;
    rom_addr = 32'h0;
    ld_start = 1'b0;
    ld_len   = '0;
    ld_valid = 1'b0;
    ld_byte  = 8'h0;
    for (int i = 0; i < DEPTH; i++) known[i] = 1'b0;

    repeat (3) begin
      tick();
      check_b("rst_cpu_rst", cpu_rst, 1'b1);
      check_w("rst_rom_data", rom_data, 32'h0);
      check_b("rst_ready", ld_ready, 1'b0);
      check_b("rst_busy", busy, 1'b0);
      check_b("rst_done", done, 1'b0);
    end
    rst = 1'b1;
    tick();
    check_b("idle_cpu_rst", cpu_rst, 1'b0);
    check_b("idle_busy", busy, 1'b0);
    rom_ce = 1'b0;
    #1;
    check_w("ce_low_fetch", rom_data, 32'h0);

    ld_start = 1'b1;
    ld_len   = '0;
    tick();
    ld_start = 1'b0;
    check_b("len0_busy", busy, 1'b0);
    check_b("len0_ready", ld_ready, 1'b0);
    check_b("len0_cpu_rst", cpu_rst, 1'b0);
    tick();
    check_b("len0_still_idle", busy, 1'b0);

    pre_q = '{8'h34, 8'h02, 8'h00, 8'h01, 8'h3C, 8'h03, 8'h12, 8'h34};
    run_load(2, 0, -1);
    fetch_const("two_word_0x0", 32'h0, 32'h34020001);
    fetch_const("two_word_0x4", 32'h4, 32'h3C031234);
    fetch_const("two_word_0x6", 32'h6, 32'h3C031234);
    fetch_const("out_of_range_0x1000", 32'h1000, 32'h0);
    fetch_const("out_of_range_high", 32'h8000_0004, 32'h0);
    rom_ce = 1'b0;
    #1;
    check_w("ce_low_after_load", rom_data, 32'h0);

    pre_q = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    run_load(1, 1, -1);
    fetch_const("gapped_word0", 32'h0, 32'hDEADBEEF);
    fetch_const("word1_persists", 32'h4, 32'h3C031234);

    run_load(7, 2, -1);
    for (int i = 0; i < 8; i++) fetch_chk("random_len7", 32'(i * 4 + $urandom_range(0, 3)));

    run_load(2047, 0, -1);
    fetch_chk("clamp_last_word", 32'hFFC);
    for (int i = 0; i < 16; i++) fetch_chk("clamp_random", rand_addr());
    fetch_const("clamp_0x1000", 32'h1000, 32'h0);

    old1 = model_mem[1];
    run_load(2, 0, 6);
    fetch_chk("abort_word0_new", 32'h0);
    fetch_const("abort_word1_old", 32'h4, old1);

    pre_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    run_load(1, 2, -1);
    fetch_const("post_abort_word0", 32'h0, 32'h11223344);
    fetch_const("post_abort_word1", 32'h4, old1);

    repeat (4) run_load($urandom_range(1, 20), 2, -1);
    for (int i = 0; i < 40; i++) fetch_chk("final_sweep", rand_addr());
    fetch_chk("final_top_word", 32'hFFC);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
